// File: rtl/usb_boot_ctrl.sv
// usb_boot_ctrl
//   Boot sequencer sitting between the USB engine and SB_WARMBOOT. It tracks SOF
//   tokens to decide whether a host is present and drives BOOT/S1/S0 so the part
//   warm-boots into the user image after an explicit request (after a drain delay
//   that lets the final ACK leave) or when no host is seen for a full timeout.
//
//   Ports
//     clk           in   48 MHz system clock
//     reset_n       in   asynchronous active-low reset
//     sof_valid     in   1-cycle pulse per received SOF
//     frame_index   in   [10:0] SOF frame number, valid with sof_valid
//     boot_req      in   boot-to-user request, level or pulse
//     boot          out  SB_WARMBOOT.BOOT, sticky once set
//     boot_sel      out  [1:0] SB_WARMBOOT {S1,S0}
//     host_present  out  host detected (contiguous SOF run seen)
//     state         out  [1:0] debug state
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | no host detected yet, waiting for SOFs or request
//   PRES  | host present, waiting for request or host loss
//   DRAIN | request accepted, counting down before boot
//   BOOT  | terminal, BOOT held high until reset
module usb_boot_ctrl #(
    parameter int unsigned PRESENCE_TIMEOUT_CYC = 48000000,
    parameter int unsigned HOST_SEEN_SOFS       = 3,
    parameter int unsigned DRAIN_CYC            = 48000,
    parameter logic [1:0]  BOOT_IMAGE           = 2'b01
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sof_valid,
    input  logic [10:0] frame_index,
    input  logic        boot_req,
    output logic        boot,
    output logic [1:0]  boot_sel,
    output logic        host_present,
    output logic [1:0]  state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRES  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_BOOT  = 2'd3;

    localparam int              RUN_W      = $clog2(HOST_SEEN_SOFS + 1);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(HOST_SEEN_SOFS);
    localparam logic [31:0]     TIMEOUT    = 32'(PRESENCE_TIMEOUT_CYC);
    localparam logic [31:0]     DRAIN_LOAD = 32'(DRAIN_CYC - 1);

    logic [31:0]      sof_timer;
    logic [RUN_W-1:0] sof_run;
    logic [31:0]      drain_cnt;
    logic [10:0]      prev_frame;
    logic [1:0]       state_nxt;
    logic             timeout;
    logic             frame_contig;

    // An SOF arriving in the same cycle the timer saturates rescues the host.
    assign timeout = (sof_timer == TIMEOUT) && !sof_valid;

    // 11-bit add wraps, so frame 2047 followed by 0 counts as contiguous.
    assign frame_contig = (frame_index == prev_frame + 11'd1);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_PRES: begin
                if (timeout)
                    state_nxt = ST_BOOT;
                else if (boot_req)
                    state_nxt = ST_DRAIN;
                else if (state == ST_IDLE && host_present)
                    state_nxt = ST_PRES;
                else if (state == ST_PRES && !host_present)
                    state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (drain_cnt == 32'd0)
                    state_nxt = ST_BOOT;
            end
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            boot         <= 1'b0;
            boot_sel     <= BOOT_IMAGE;
            host_present <= 1'b0;
            sof_timer    <= 32'd0;
            sof_run      <= '0;
            drain_cnt    <= 32'd0;
            prev_frame   <= 11'd0;
        end else begin
            state    <= state_nxt;
            boot     <= (state_nxt == ST_BOOT);
            boot_sel <= BOOT_IMAGE;

            if (sof_valid)
                sof_timer <= 32'd0;
            else if (sof_timer != TIMEOUT)
                sof_timer <= sof_timer + 32'd1;

            if (sof_valid) begin
                if (sof_run == '0 || !frame_contig)
                    sof_run <= RUN_W'(1);
                else if (sof_run != RUN_MAX)
                    sof_run <= sof_run + RUN_W'(1);
                prev_frame <= frame_index;
            end

            // Only host loss clears presence; a broken SOF run does not.
            if (timeout)
                host_present <= 1'b0;
            else if (sof_run == RUN_MAX)
                host_present <= 1'b1;

            if (state_nxt == ST_DRAIN && state != ST_DRAIN)
                drain_cnt <= DRAIN_LOAD;
            else if (state == ST_DRAIN && drain_cnt != 32'd0)
                drain_cnt <= drain_cnt - 32'd1;
        end
    end

endmodule

// File: tb/tb_usb_boot_ctrl.sv
module tb_usb_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sof_valid = 1'b0;
    logic [10:0] frame_index = 11'd0;
    logic        boot_req = 1'b0;
    logic        boot;
    logic [1:0]  boot_sel;
    logic        host_present;
    logic [1:0]  state;

    usb_boot_ctrl #(
        .PRESENCE_TIMEOUT_CYC(100),
        .HOST_SEEN_SOFS(3),
        .DRAIN_CYC(10),
        .BOOT_IMAGE(2'b01)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sof_valid(sof_valid),
        .frame_index(frame_index),
        .boot_req(boot_req),
        .boot(boot),
        .boot_sel(boot_sel),
        .host_present(host_present),
        .state(state)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; stable while clk is low.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected response; at < 0 means "check right now", field < 0 means don't care.
    typedef struct {
        int    at;
        string name;
        int    st;
        int    bt;
        int    hp;
    } exp_t;

    exp_t exp_q[$];
    event chk_now;
    bit   done = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic push(input int at, input string name, input int st, input int bt, input int hp);
        exp_t e;
        e.at = at; e.name = name; e.st = st; e.bt = bt; e.hp = hp;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_entry(input exp_t e);
        if (e.st >= 0) cmp({e.name, ".state"}, 32'(state), 32'(e.st));
        if (e.bt >= 0) cmp({e.name, ".boot"}, 32'(boot), 32'(e.bt));
        if (e.hp >= 0) cmp({e.name, ".host_present"}, 32'(host_present), 32'(e.hp));
        cmp({e.name, ".boot_sel"}, 32'(boot_sel), 32'd1);
    endtask

    // Monitor: owns all comparisons and the summary.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if ((!clk && exp_q[i].at >= 0 && exp_q[i].at <= cyc) || exp_q[i].at < 0) begin
                    check_entry(exp_q[i]);
                    exp_q.delete(i);
                end
            end
            if (done) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s never checked: due cyc %0d now %0d", exp_q[i].name, exp_q[i].at, cyc);
                end
                $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic sof_at(input int c, input logic [10:0] f);
        wait_until(c);
        sof_valid   = 1'b1;
        frame_index = f;
        @(negedge clk);
        sof_valid   = 1'b0;
    endtask

    task automatic req_at(input int c);
        wait_until(c);
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic reset_dut(output int c0);
        @(negedge clk);
        reset_n = 1'b0;
        push(cyc + 1, "reset", 0, 0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        c0 = cyc;
    endtask

    int c0;
    int c;

    initial begin
        // 1: no host ever -> timeout boot after 101 cycles
        reset_dut(c0);
        push(c0 + 1,   "t1_c1",   0, 0, 0);
        push(c0 + 50,  "t1_c50",  0, 0, 0);
        push(c0 + 100, "t1_c100", 0, 0, 0);
        push(c0 + 101, "t1_c101", 3, 1, -1);
        push(c0 + 120, "t1_stay", 3, 1, -1);
        wait_until(c0 + 125);

        // 2: SOFs across the frame wrap, host detected, no boot while SOFs keep coming
        reset_dut(c0);
        sof_at(c0 + 40, 11'd2046);
        sof_at(c0 + 90, 11'd2047);
        push(c0 + 141, "t2_hp_before", 0, 0, 0);
        push(c0 + 142, "t2_hp_set", -1, 0, 1);
        push(c0 + 145, "t2_present", 1, 0, 1);
        sof_at(c0 + 140, 11'd0);
        push(c0 + 200, "t2_hold1", 1, 0, 1);
        push(c0 + 300, "t2_hold2", 1, 0, 1);
        sof_at(c0 + 190, 11'd1);
        sof_at(c0 + 240, 11'd2);
        sof_at(c0 + 290, 11'd3);

        // 3: boot request from PRESENT, second request inside DRAIN changes nothing
        c = c0 + 310;
        push(c + 1,  "t3_drain", 2, 0, -1);
        push(c + 10, "t3_drain_last", 2, 0, -1);
        push(c + 11, "t3_boot", 3, 1, -1);
        push(c + 30, "t3_stay", 3, 1, -1);
        req_at(c);
        req_at(c + 5);
        wait_until(c + 35);

        // 4: broken SOF run 5,6,9,10 never reaches 3; frame 11 then completes a run
        reset_dut(c0);
        sof_at(c0 + 20, 11'd5);
        sof_at(c0 + 40, 11'd6);
        sof_at(c0 + 60, 11'd9);
        push(c0 + 85, "t4_no_host_a", 0, 0, 0);
        push(c0 + 95, "t4_no_host_b", 0, 0, 0);
        push(c0 + 101, "t4_pre11", 0, 0, 0);
        push(c0 + 102, "t4_run3", -1, 0, 1);
        sof_at(c0 + 80, 11'd10);
        sof_at(c0 + 100, 11'd11);
        wait_until(c0 + 110);

        // 5: SOF wins against timeout; later timeout + boot_req skips DRAIN
        reset_dut(c0);
        push(c0 + 101, "t5_sof_wins", 0, 0, 0);
        push(c0 + 150, "t5_no_boot", 0, 0, 0);
        push(c0 + 201, "t5_pre", 0, 0, 0);
        push(c0 + 202, "t5_direct_boot", 3, 1, -1);
        push(c0 + 210, "t5_stay", 3, 1, -1);
        sof_at(c0 + 100, 11'd7);
        req_at(c0 + 201);
        wait_until(c0 + 215);

        // 6: async reset mid-DRAIN, then full restart from IDLE
        reset_dut(c0);
        push(c0 + 11, "t6_drain", 2, 0, 0);
        push(c0 + 15, "t6_drain5", 2, 0, 0);
        req_at(c0 + 10);
        wait_until(c0 + 15);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        push(-1, "t6_async_rst", 0, 0, 0);
        -> chk_now;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        c0 = cyc;
        push(c0 + 20,  "t6_idle", 0, 0, 0);
        push(c0 + 100, "t6_pre_to", 0, 0, 0);
        push(c0 + 101, "t6_to_boot", 3, 1, -1);
        wait_until(c0 + 105);

        reset_dut(c0);
        push(c0 + 31, "t6_drain2", 2, 0, 0);
        push(c0 + 40, "t6_drain2_last", 2, 0, 0);
        push(c0 + 41, "t6_boot2", 3, 1, -1);
        req_at(c0 + 30);
        wait_until(c0 + 45);

        #1;
        done = 1'b1;
        -> chk_now;
    end

endmodule
